// File: rtl/uart_tx_block_if.sv
// Bus-side bundle for the UART transmitter: byte write strobe, frame config and line/status outputs.
// Pure wiring, no latency of its own.
// No backpressure signal; the producer watches buffer_empty and overrun_error.
interface uart_tx_block_if;
    logic [7:0]  tx_data;
    logic        data_write;
    logic [3:0]  data_size;
    logic [13:0] bit_period;
    logic        serial_out;
    logic        buffer_empty;
    logic        tx_busy;
    logic        tx_done;
    logic        overrun_error;

    // Producer side: writes bytes and configuration, observes status.
    modport master (
        output tx_data,
        output data_write,
        output data_size,
        output bit_period,
        input  serial_out,
        input  buffer_empty,
        input  tx_busy,
        input  tx_done,
        input  overrun_error
    );

    // Transmitter side.
    modport slave (
        input  tx_data,
        input  data_write,
        input  data_size,
        input  bit_period,
        output serial_out,
        output buffer_empty,
        output tx_busy,
        output tx_done,
        output overrun_error
    );
endinterface

// File: rtl/uart_tx_block.sv
// UART transmitter: 1 start, 5..8 data bits LSB first, 1 stop, with a one-byte holding buffer.
// Write in cycle N (idle) -> buffer full N+1 -> start bit on serial_out from N+2.
// Writes into a full, non-draining buffer are dropped and raise a sticky overrun_error.
module uart_tx_block (
    input  logic           clk,
    input  logic           n_rst,
    uart_tx_block_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_nxt;

    // Frame configuration captured when a frame starts, so mid-frame changes wait a frame.
    logic [13:0] per_q;
    logic [3:0]  size_q;
    logic [13:0] per_eff;
    logic [3:0]  size_eff;

    logic [13:0] tmr_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  shift_nxt;

    logic [7:0]  buf_dat_q;
    logic        buf_full_q;
    logic        ovr_q;

    logic        serial_q;
    logic        serial_d;

    logic        tmr_last;
    logic        bit_last;
    logic        frame_end;
    logic        load;
    logic        accept;

    // Out-of-range settings fall back to safe values: period below 2 -> 2, size outside 5..8 -> 8.
    assign per_eff  = (bus.bit_period < 14'd2) ? 14'd2 : bus.bit_period;
    assign size_eff = ((bus.data_size >= 4'd5) && (bus.data_size <= 4'd8)) ? bus.data_size : 4'd8;

    assign tmr_last  = (tmr_q == (per_q - 14'd1));
    assign bit_last  = ({1'b0, bit_cnt_q} == (size_q - 4'd1));
    assign frame_end = (state_q == S_STOP) && tmr_last;

    // A frame starts either from idle or straight out of the stop bit, whenever a byte is waiting.
    assign load   = buf_full_q && ((state_q == S_IDLE) || frame_end);

    // The buffer slot is free if empty, or if its byte moves to the shifter this same cycle.
    assign accept = bus.data_write && (!buf_full_q || load);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: each line state lasts whole bit periods.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (tmr_last) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (tmr_last && bit_last) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (tmr_last) begin
                    state_nxt = buf_full_q ? S_START : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Shifter next value: load the buffered byte on frame start, shift right at each data bit boundary.
    always_comb begin
        shift_nxt = shift_q;
        if (load) begin
            shift_nxt = buf_dat_q;
        end else if ((state_q == S_DATA) && tmr_last) begin
            shift_nxt = {1'b0, shift_q[7:1]};
        end
    end

    // Output logic: line level is decoded from the upcoming state so serial_out can be a flop.
    always_comb begin
        serial_d = 1'b1;
        case (state_nxt)
            S_START: serial_d = 1'b0;
            S_DATA:  serial_d = shift_nxt[0];
            default: serial_d = 1'b1;
        endcase
    end

    // Bit timer, bit counter, shifter and per-frame configuration.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            per_q     <= 14'd2;
            size_q    <= 4'd8;
        end else begin
            shift_q <= shift_nxt;
            if (load) begin
                tmr_q     <= '0;
                bit_cnt_q <= '0;
                per_q     <= per_eff;
                size_q    <= size_eff;
            end else if (state_q != S_IDLE) begin
                tmr_q <= tmr_last ? 14'd0 : (tmr_q + 14'd1);
                if ((state_q == S_DATA) && tmr_last) begin
                    bit_cnt_q <= bit_last ? 3'd0 : (bit_cnt_q + 3'd1);
                end
            end
        end
    end

    // Holding buffer and sticky overrun flag; an accepted write always clears the flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_dat_q  <= '0;
            buf_full_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (accept) begin
                buf_dat_q  <= bus.tx_data;
                buf_full_q <= 1'b1;
                ovr_q      <= 1'b0;
            end else begin
                if (load) begin
                    buf_full_q <= 1'b0;
                end
                if (bus.data_write) begin
                    ovr_q <= 1'b1;
                end
            end
        end
    end

    // Registered line driver; reset forces the line back to idle-high immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            serial_q <= 1'b1;
        end else begin
            serial_q <= serial_d;
        end
    end

    assign bus.serial_out    = serial_q;
    assign bus.buffer_empty  = !buf_full_q;
    assign bus.tx_busy       = (state_q != S_IDLE);
    assign bus.tx_done       = frame_end;
    assign bus.overrun_error = ovr_q;

endmodule

// File: doc/uart_tx_block.md
Name: uart_tx_block

Overview:
UART transmitter: serializes parallel bytes into frames of 1 start bit, 5–8 data bits (LSB first) and 1 stop bit on `serial_out`. It is the transmit counterpart to the receive block and uses the same `data_size` / `bit_period` configuration, so a TX→RX loopback shares one setting. A one-entry holding buffer lets the bus side queue the next byte while the current frame shifts out. Internally it contains a control FSM, a bit-period timer, a bit counter, a shift register and the holding buffer.

Parameters:
- None. Widths are fixed to match the receive side.

Ports:
- `clk`  input  1  system clock, rising edge.
- `n_rst`  input  1  asynchronous, active-low reset.
- `tx_data`  input  8  byte to transmit. Bits above `data_size` are ignored.
- `data_write`  input  1  single-cycle strobe: write `tx_data` into the holding buffer.
- `data_size`  input  4  data bits per frame. Legal values are 5..8; any other value is treated as 8.
- `bit_period`  input  14  clock cycles per bit. Values 0 and 1 are treated as 2.
- `serial_out`  output  1  serial line, idle high, registered.
- `buffer_empty`  output  1  high when the holding buffer can accept a byte.
- `tx_busy`  output  1  high while a frame is on the line (START, DATA or STOP state).
- `tx_done`  output  1  one-cycle pulse in the last cycle of the stop bit.
- `overrun_error`  output  1  sticky flag: a write was attempted while the buffer was full.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: `serial_out`=1, `buffer_empty`=1, `tx_busy`=0, `tx_done`=0, `overrun_error`=0. FSM=IDLE, timer and bit counter =0.
- FSM states:
  - IDLE → START when the buffer is full.
  - START → DATA after `bit_period` cycles.
  - DATA → STOP after `data_size` bits, each lasting `bit_period` cycles.
  - STOP → START if the buffer is full in the last STOP cycle; otherwise STOP → IDLE.
- Load on frame start, on the edge entering START:
  - buffer byte transfers to the shift register;
  - `data_size` and `bit_period` are sampled and held for the whole frame; mid-frame changes take effect at the next frame;
  - the buffer is marked empty.
- `serial_out` by state:
  - 0 in START;
  - shift register bit 0 in DATA, shifting right at each bit boundary;
  - 1 in STOP and IDLE.
- Timer: counts 0..`bit_period`-1 and wraps; the bit boundary is at count = `bit_period`-1. Frame length is exactly (`data_size`+2)×`bit_period` cycles.
- Latency: `data_write` accepted in cycle N while IDLE → buffer full in N+1 → `serial_out`=0 from cycle N+2.
- Back-to-back frames: no idle cycle between the stop bit and the next start bit when the buffer is full at the end of STOP.
- Write acceptance: a write is accepted if the buffer is empty, or if it is being transferred to the shifter in that same cycle.
  - On acceptance: `buffer_empty` goes low the next cycle, and `overrun_error` clears.
- Write rejection: a write while the buffer is full and not transferring is dropped; the buffer keeps its old byte and `overrun_error`=1 the next cycle.
- `tx_done` is asserted combinationally with the last STOP cycle: the timer at `bit_period`-1 in STOP.
- Reset mid-frame: the line returns high immediately (asynchronous), the frame is aborted and the buffered byte is discarded.

Test Plan:
1. `bit_period`=10, `data_size`=8, write 0xA5 while idle → `serial_out` low at N+2 for 10 cycles, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then 10 cycles high. `tx_done` pulses once, at cycle 99 of the frame. `tx_busy` is high for 100 cycles.
2. `data_size`=5, `bit_period`=4, write 0xE3 → data bits 1,1,0,0,0; frame is 28 cycles. `data_size`=12 sends 8 bits (40-cycle frame).
3. Back-to-back: write 0x55, then 0x0F during the first frame's DATA state → `buffer_empty`=0 until the second START. The second start bit immediately follows the first stop bit with 0 idle cycles; `tx_done` pulses twice.
4. Overrun: write 0x11 (starts the frame), write 0x22 (buffered), write 0x33 while busy → 0x33 is dropped and `overrun_error`=1. After 0x22 loads, writing 0x44 is accepted and `overrun_error` clears. Line sequence is 0x11, 0x22, 0x44.
5. Simultaneous: the write is timed to the last STOP cycle with the buffer full → the new byte is accepted, `overrun_error` stays 0, and it is sent after the transferred byte.
6. `n_rst` asserted in the middle of DATA → `serial_out`=1 and `buffer_empty`=1 with no clock edge. After release, a write of 0x81 with `bit_period`=1 (treated as 2) produces an 20-cycle frame.
